// File: rtl/dsi_rx_packet_parser.sv
// dsi_rx_packet_parser: DSI receive parser, header ECC check/correct, payload CRC check, payload streaming
module dsi_rx_packet_parser #(
  parameter int CNT_W     = 16,
  parameter bit CHECK_CRC = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sot,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic             eot,
  output logic             hdr_valid,
  output logic [7:0]       hdr_di,
  output logic [15:0]      hdr_wc,
  output logic             hdr_long,
  output logic             ecc_corr,
  output logic             ecc_err,
  output logic [7:0]       pl_data,
  output logic             pl_valid,
  output logic             pl_last,
  output logic             pkt_done,
  output logic             crc_ok,
  output logic             trunc_err,
  output logic [CNT_W-1:0] err_cnt_ecc,
  output logic [CNT_W-1:0] err_cnt_crc
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CRC} state_t;
  // syndrome produced by each header data bit, ECC bits P5..P0
  localparam logic [5:0] COL [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                                      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                                      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  state_t state_q, state_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [23:0] hbuf_q, hbuf_d, fixed;
  logic [15:0] cnt_q, cnt_d, crc_q, crc_d, hdr_wc_q, hdr_wc_d;
  logic [7:0] crlo_q, crlo_d, hdr_di_q, hdr_di_d, pl_data_q, pl_data_d;
  logic [5:0] syn;
  logic hdr_ok, corr, is_long, mid;
  logic hdr_valid_q, hdr_valid_d, hdr_long_q, hdr_long_d, ecc_corr_q, ecc_corr_d, ecc_err_q, ecc_err_d;
  logic pl_valid_q, pl_valid_d, pl_last_q, pl_last_d, pkt_done_q, pkt_done_d;
  logic crc_ok_q, crc_ok_d, trunc_err_q, trunc_err_d;
  logic [CNT_W-1:0] err_cnt_ecc_q, err_cnt_ecc_d, err_cnt_crc_q, err_cnt_crc_d;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 16'h8408 : r >> 1;
    return r;
  endfunction

  always_comb begin
    syn = din[5:0];
    for (int i = 0; i < 24; i++) syn = hbuf_q[i] ? syn ^ COL[i] : syn;
    fixed = hbuf_q;
    corr = syn != 6'd0 && (syn & (syn - 6'd1)) == 6'd0;
    for (int i = 0; i < 24; i++) begin
      if (syn == COL[i]) begin
        fixed[i] = ~hbuf_q[i];
        corr = 1'b1;
      end
    end
    hdr_ok = syn == 6'd0 || corr;
    is_long = fixed[3:0] inside {4'h9, 4'hC, 4'hD, 4'hE};
  end

  always_comb begin
    state_d = state_q;
    bcnt_d = bcnt_q;
    hbuf_d = hbuf_q;
    cnt_d = cnt_q;
    crc_d = crc_q;
    crlo_d = crlo_q;
    hdr_di_d = hdr_di_q;
    hdr_wc_d = hdr_wc_q;
    hdr_long_d = hdr_long_q;
    pl_data_d = pl_data_q;
    crc_ok_d = crc_ok_q;
    hdr_valid_d = 1'b0;
    ecc_corr_d = 1'b0;
    ecc_err_d = 1'b0;
    pl_valid_d = 1'b0;
    pl_last_d = 1'b0;
    pkt_done_d = 1'b0;
    trunc_err_d = 1'b0;
    mid = (state_q == HDR && bcnt_q != 2'd0) || state_q == PAYLOAD || state_q == CRC;
    if (eot) begin
      trunc_err_d = mid;
      state_d = IDLE;
      bcnt_d = 2'd0;
    end else if (sot && din_valid) begin
      trunc_err_d = mid;
      state_d = HDR;
      hbuf_d[7:0] = din;
      bcnt_d = 2'd1;
    end else if (din_valid) begin
      case (state_q)
        HDR: begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q != 2'd3) hbuf_d[{bcnt_q, 3'b000} +: 8] = din;
          else if (!hdr_ok) begin
            ecc_err_d = 1'b1;
            state_d = IDLE;
          end else begin
            hdr_valid_d = 1'b1;
            ecc_corr_d = corr;
            hdr_di_d = fixed[7:0];
            hdr_wc_d = fixed[23:8];
            hdr_long_d = is_long;
            cnt_d = fixed[23:8];
            crc_d = 16'hFFFF;
            state_d = !is_long ? HDR : fixed[23:8] == 16'd0 ? CRC : PAYLOAD;
          end
        end
        PAYLOAD: begin
          pl_valid_d = 1'b1;
          pl_data_d = din;
          pl_last_d = cnt_q == 16'd1;
          crc_d = crc_byte(crc_q, din);
          cnt_d = cnt_q - 16'd1;
          state_d = cnt_q == 16'd1 ? CRC : PAYLOAD;
        end
        CRC: begin
          bcnt_d = bcnt_q == 2'd0 ? 2'd1 : 2'd0;
          crlo_d = din;
          pkt_done_d = bcnt_q != 2'd0;
          crc_ok_d = bcnt_q != 2'd0 ? ({din, crlo_q} == crc_q) || !CHECK_CRC : crc_ok_q;
          state_d = bcnt_q != 2'd0 ? HDR : CRC;
        end
        default: ;
      endcase
    end
    err_cnt_ecc_d = (ecc_err_d && !(&err_cnt_ecc_q)) ? err_cnt_ecc_q + ONE : err_cnt_ecc_q;
    err_cnt_crc_d = (pkt_done_d && !crc_ok_d && !(&err_cnt_crc_q)) ? err_cnt_crc_q + ONE : err_cnt_crc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bcnt_q <= '0;
      hbuf_q <= '0;
      cnt_q <= '0;
      crc_q <= 16'hFFFF;
      crlo_q <= '0;
      hdr_di_q <= '0;
      hdr_wc_q <= '0;
      hdr_long_q <= 1'b0;
      pl_data_q <= '0;
      crc_ok_q <= 1'b0;
      hdr_valid_q <= 1'b0;
      ecc_corr_q <= 1'b0;
      ecc_err_q <= 1'b0;
      pl_valid_q <= 1'b0;
      pl_last_q <= 1'b0;
      pkt_done_q <= 1'b0;
      trunc_err_q <= 1'b0;
      err_cnt_ecc_q <= '0;
      err_cnt_crc_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      hbuf_q <= hbuf_d;
      cnt_q <= cnt_d;
      crc_q <= crc_d;
      crlo_q <= crlo_d;
      hdr_di_q <= hdr_di_d;
      hdr_wc_q <= hdr_wc_d;
      hdr_long_q <= hdr_long_d;
      pl_data_q <= pl_data_d;
      crc_ok_q <= crc_ok_d;
      hdr_valid_q <= hdr_valid_d;
      ecc_corr_q <= ecc_corr_d;
      ecc_err_q <= ecc_err_d;
      pl_valid_q <= pl_valid_d;
      pl_last_q <= pl_last_d;
      pkt_done_q <= pkt_done_d;
      trunc_err_q <= trunc_err_d;
      err_cnt_ecc_q <= err_cnt_ecc_d;
      err_cnt_crc_q <= err_cnt_crc_d;
    end
  end

  assign hdr_valid = hdr_valid_q;
  assign hdr_di = hdr_di_q;
  assign hdr_wc = hdr_wc_q;
  assign hdr_long = hdr_long_q;
  assign ecc_corr = ecc_corr_q;
  assign ecc_err = ecc_err_q;
  assign pl_data = pl_data_q;
  assign pl_valid = pl_valid_q;
  assign pl_last = pl_last_q;
  assign pkt_done = pkt_done_q;
  assign crc_ok = crc_ok_q;
  assign trunc_err = trunc_err_q;
  assign err_cnt_ecc = err_cnt_ecc_q;
  assign err_cnt_crc = err_cnt_crc_q;
endmodule
